regfile_mp: RTL

//  Parametrised multi-port register file for the pipelined core (successor of the 2R/1W file).
//  NRP read / NWP write ports with same-cycle write-to-read bypass, hardwired-zero r0,

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_mp_if.sv | 24 ++
 rtl/regfile_bypass_mux.sv | 25 ++
 rtl/regfile_mp.sv | 96 +++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, FSM state type and address-validity helper for regfile_mp
package regfile_pkg;
  localparam int RF_DW       = 32;
  localparam int RF_NREG     = 32;
  localparam int RF_AW       = $clog2(RF_NREG);
  localparam int RF_NRP      = 2;
  localparam int RF_NWP      = 2;
  localparam int RF_SPEC_REG = 30;
  typedef enum logic {ST_CLEAR, ST_RUN} state_e;
  function automatic logic addr_ok(int a, int nreg);
    return a != 0 && a < nreg;
  endfunction
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: decode/writeback side bus of the multi-port register file
interface regfile_mp_if import regfile_pkg::*; #(
  parameter int DW   = RF_DW,
  parameter int NREG = RF_NREG,
  parameter int NRP  = RF_NRP,
  parameter int NWP  = RF_NWP,
  localparam int AW  = $clog2(NREG)
);
  logic [NRP*AW-1:0] ra;
  logic [NRP*DW-1:0] rd;
  logic [NRP-1:0]    rd_pend;
  logic [NWP-1:0]    we;
  logic [NWP*AW-1:0] wa;
  logic [NWP*DW-1:0] wd;
  logic              alloc_we;
  logic [AW-1:0]     alloc_a;
  logic              spec_we;
  logic [DW-1:0]     spec_wd;
  logic [DW-1:0]     spec_out;
  modport master (output ra, we, wa, wd, alloc_we, alloc_a, spec_we, spec_wd,
                  input rd, rd_pend, spec_out);
  modport slave  (input ra, we, wa, wd, alloc_we, alloc_a, spec_we, spec_wd,
                  output rd, rd_pend, spec_out);
endinterface

// File: rtl/regfile_bypass_mux.sv
// regfile_bypass_mux: priority select of in-flight write data over the array value
module regfile_bypass_mux import regfile_pkg::*; #(
  parameter int DW = RF_DW,
  parameter int AW = RF_AW,
  parameter int NW = RF_NWP + 1
)(
  input  logic [AW-1:0]    addr_i,
  input  logic [NW-1:0]    we_i,
  input  logic [NW*AW-1:0] wa_i,
  input  logic [NW*DW-1:0] wd_i,
  input  logic [DW-1:0]    arr_i,
  output logic [DW-1:0]    d_o,
  output logic             hit_o
);
  // later sources override earlier ones, matching the array write order
  always_comb begin
    d_o = arr_i;
    hit_o = 1'b0;
    for (int i = 0; i < NW; i++)
      if (we_i[i] && wa_i[i*AW +: AW] == addr_i) begin
        d_o = wd_i[i*DW +: DW];
        hit_o = 1'b1;
      end
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: NRP-read / NWP-write register file with bypass, r0, link port,
// pending scoreboard and a one-register-per-cycle clear sweep
module regfile_mp import regfile_pkg::*; #(
  parameter int DW       = RF_DW,
  parameter int NREG     = RF_NREG,
  parameter int NRP      = RF_NRP,
  parameter int NWP      = RF_NWP,
  parameter int SPEC_REG = RF_SPEC_REG,
  localparam int AW      = $clog2(NREG),
  localparam int NS      = NWP + 1
)(
  input  logic clk,
  input  logic rst_n,
  input  logic clr_req_i,
  output logic ready_o,
  regfile_mp_if.slave bus
);
  localparam logic [AW-1:0] SA = AW'(SPEC_REG);
  state_e            st_q, st_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic [NREG-1:0]   pend_q, pend_d;
  logic [DW-1:0]     mem_q [NREG];
  logic [DW-1:0]     mem_d [NREG];
  logic              run, alloc_v, unused_spec_hit;
  logic [NS-1:0]     wev;
  logic [NS*AW-1:0]  wa_all;
  logic [NS*DW-1:0]  wd_all;
  assign run = st_q == ST_RUN;
  assign ready_o = run;
  // the link port is the highest-priority write source
  assign wa_all = {SA, bus.wa};
  assign wd_all = {bus.spec_wd, bus.wd};
  assign alloc_v = run && bus.alloc_we && addr_ok(int'(bus.alloc_a), NREG);
  always_comb begin
    for (int i = 0; i < NWP; i++)
      wev[i] = run && bus.we[i] && addr_ok(int'(bus.wa[i*AW +: AW]), NREG);
    wev[NWP] = run && bus.spec_we;
  end
  always_comb begin
    st_d = st_q;
    ptr_d = ptr_q;
    if (!run) begin
      ptr_d = ptr_q + 1'b1;
      if (int'(ptr_q) == NREG - 1) begin
        st_d = ST_RUN;
        ptr_d = '0;
      end
    end else if (clr_req_i) begin
      st_d = ST_CLEAR;
      ptr_d = '0;
    end
  end
  always_comb begin
    mem_d = mem_q;
    if (!run) mem_d[ptr_q] = '0;
    for (int i = 0; i < NS; i++)
      if (wev[i]) mem_d[wa_all[i*AW +: AW]] = wd_all[i*DW +: DW];
  end
  // a new allocation outranks a completing write to the same register
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < NS; i++)
      if (wev[i]) pend_d[wa_all[i*AW +: AW]] = 1'b0;
    if (alloc_v) pend_d[bus.alloc_a] = 1'b1;
    if (!run || clr_req_i) pend_d = '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st_q <= ST_CLEAR;
      ptr_q <= '0;
      pend_q <= '0;
    end else begin
      st_q <= st_d;
      ptr_q <= ptr_d;
      pend_q <= pend_d;
    end
  always_ff @(posedge clk) mem_q <= mem_d;
  for (genvar p = 0; p < NRP; p++) begin : g_rd
    logic [AW-1:0] a;
    logic [DW-1:0] arr, d;
    logic          v, hit;
    assign a = bus.ra[p*AW +: AW];
    assign v = run && addr_ok(int'(a), NREG);
    assign arr = v ? mem_q[a] : '0;
    regfile_bypass_mux #(.DW(DW), .AW(AW), .NW(NS)) u_mux (
      .addr_i(a), .we_i(wev), .wa_i(wa_all), .wd_i(wd_all),
      .arr_i(arr), .d_o(d), .hit_o(hit)
    );
    assign bus.rd[p*DW +: DW] = d;
    assign bus.rd_pend[p] = v && pend_q[a] && !(hit && !(alloc_v && bus.alloc_a == a));
  end
  regfile_bypass_mux #(.DW(DW), .AW(AW), .NW(NS)) u_spec (
    .addr_i(SA), .we_i(wev), .wa_i(wa_all), .wd_i(wd_all),
    .arr_i(run ? mem_q[SPEC_REG] : '0), .d_o(bus.spec_out), .hit_o(unused_spec_hit)
  );
endmodule
